// File: rtl/id_operand_stage.sv
// id_operand_stage: decode/operand fetch with write-back bypass, load scoreboard stall, ID/EX register and saturating stall counter
module id_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_valid,
  output logic                  if_ready,
  input  logic [31:0]           if_instr,
  input  logic [PC_WIDTH-1:0]   if_pc,
  input  logic                  flush,
  output logic [4:0]            rf_addr_rd1,
  output logic [4:0]            rf_addr_rd2,
  input  logic [DATA_WIDTH-1:0] rf_data_rd1,
  input  logic [DATA_WIDTH-1:0] rf_data_rd2,
  input  logic                  wb_wr_en,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output logic [PC_WIDTH-1:0]   ex_pc,
  output logic [31:0]           ex_instr,
  output logic [4:0]            ex_rs1,
  output logic [4:0]            ex_rs2,
  output logic [DATA_WIDTH-1:0] ex_rs1_data,
  output logic [DATA_WIDTH-1:0] ex_rs2_data,
  output logic [4:0]            ex_rd,
  output logic                  ex_is_load,
  output logic [CNT_WIDTH-1:0]  perf_stall_cnt
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_R = 7'b0110011, OP_S = 7'b0100011, OP_B = 7'b1100011, OP_LOAD = 7'b0000011;
  logic                  ex_valid_q, ex_valid_d;
  logic [PC_WIDTH-1:0]   ex_pc_q, ex_pc_d;
  logic [31:0]           ex_instr_q, ex_instr_d;
  logic [4:0]            ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_rd_q, ex_rd_d;
  logic [DATA_WIDTH-1:0] ex_rs1_data_q, ex_rs1_data_d, ex_rs2_data_q, ex_rs2_data_d;
  logic                  ex_is_load_q, ex_is_load_d;
  logic [31:0]           busy_q, busy_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [6:0]            opc;
  logic [4:0]            rs1, rs2;
  logic                  use_rs1, use_rs2, wb_hit1, wb_hit2, hzd, adv, accept, sb_set;
  logic [DATA_WIDTH-1:0] op1, op2;
  assign opc         = if_instr[6:0];
  assign rs1         = if_instr[19:15];
  assign rs2         = if_instr[24:20];
  assign rf_addr_rd1 = rs1;
  assign rf_addr_rd2 = rs2;
  assign use_rs1     = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
  assign use_rs2     = opc == OP_R || opc == OP_S || opc == OP_B;
  assign wb_hit1     = wb_wr_en && wb_addr == rs1;
  assign wb_hit2     = wb_wr_en && wb_addr == rs2;
  // x0 reads as zero; a hit on a nonzero rsX implies wb_addr != 0
  assign op1         = rs1 == 5'd0 ? '0 : wb_hit1 ? wb_data : rf_data_rd1;
  assign op2         = rs2 == 5'd0 ? '0 : wb_hit2 ? wb_data : rf_data_rd2;
  assign hzd         = (use_rs1 && busy_q[rs1] && !wb_hit1) || (use_rs2 && busy_q[rs2] && !wb_hit2);
  assign adv         = !ex_valid_q || ex_ready;
  assign if_ready    = !flush && !hzd && adv;
  assign accept      = if_valid && if_ready;
  assign sb_set      = ex_valid_q && ex_ready && ex_is_load_q && ex_rd_q != 5'd0 && !flush;
  always_comb begin
    ex_valid_d    = flush ? 1'b0 : adv ? accept : ex_valid_q;
    ex_pc_d       = accept ? if_pc : ex_pc_q;
    ex_instr_d    = accept ? if_instr : ex_instr_q;
    ex_rs1_d      = accept ? rs1 : ex_rs1_q;
    ex_rs2_d      = accept ? rs2 : ex_rs2_q;
    ex_rd_d       = accept ? if_instr[11:7] : ex_rd_q;
    ex_is_load_d  = accept ? opc == OP_LOAD : ex_is_load_q;
    ex_rs1_data_d = accept ? op1 : (wb_wr_en && wb_addr != 5'd0 && wb_addr == ex_rs1_q) ? wb_data : ex_rs1_data_q;
    ex_rs2_data_d = accept ? op2 : (wb_wr_en && wb_addr != 5'd0 && wb_addr == ex_rs2_q) ? wb_data : ex_rs2_data_q;
    busy_d        = (busy_q & ~(32'(wb_wr_en) << wb_addr)) | (32'(sb_set) << ex_rd_q);
    cnt_d         = (if_valid && hzd && !flush && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_instr_q    <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_is_load_q  <= 1'b0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      busy_q        <= '0;
      cnt_q         <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_instr_q    <= ex_instr_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_is_load_q  <= ex_is_load_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
    end
  end
  assign ex_valid       = ex_valid_q;
  assign ex_pc          = ex_pc_q;
  assign ex_instr       = ex_instr_q;
  assign ex_rs1         = ex_rs1_q;
  assign ex_rs2         = ex_rs2_q;
  assign ex_rd          = ex_rd_q;
  assign ex_is_load     = ex_is_load_q;
  assign ex_rs1_data    = ex_rs1_data_q;
  assign ex_rs2_data    = ex_rs2_data_q;
  assign perf_stall_cnt = cnt_q;
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: table vectors plus hazard/hold/flush/reset sequences checked through an expected-entry queue
module tb_id_operand_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic if_valid, if_ready, flush, wb_wr_en, ex_ready, ex_valid, ex_is_load;
  logic [31:0] if_instr, if_pc, rf_data_rd1, rf_data_rd2, wb_data, ex_pc, ex_instr, ex_rs1_data, ex_rs2_data, perf_stall_cnt;
  logic [4:0] rf_addr_rd1, rf_addr_rd2, wb_addr, ex_rs1, ex_rs2, ex_rd;
  id_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .rf_addr_rd1(rf_addr_rd1), .rf_addr_rd2(rf_addr_rd2), .rf_data_rd1(rf_data_rd1),
    .rf_data_rd2(rf_data_rd2), .wb_wr_en(wb_wr_en), .wb_addr(wb_addr), .wb_data(wb_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .perf_stall_cnt(perf_stall_cnt)
  );
  localparam logic [31:0] ADDI5 = 32'h00700293, ADDI8 = 32'h00118413, SW4 = 32'h0042A423, ADD11 = 32'h000005B3;
  localparam logic [31:0] LUI9 = 32'h123454B7, ADD7 = 32'h001303B3, LW6 = 32'h00012303, ADD12 = 32'h00408633;
  typedef struct packed {
    logic [31:0] pc, instr;
    logic [4:0]  rs1, rs2, rd;
    logic        ld;
    logic [31:0] op1, op2;
  } exp_t;
  typedef struct {
    logic [31:0] instr, rf1, rf2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd, op1, op2;
  } vec_t;
  exp_t q[$];
  exp_t m_a, m_e;
  vec_t tbl[7];
  int vecs = 0, errs = 0;
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  function automatic exp_t mk(logic [31:0] pc, logic [31:0] ins, logic [31:0] o1, logic [31:0] o2);
    exp_t e;
    e.pc = pc; e.instr = ins; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.ld = ins[6:0] == 7'b0000011; e.op1 = o1; e.op2 = o2;
    return e;
  endfunction
  task automatic drive(logic [31:0] ins, logic [31:0] pc, logic [31:0] r1, logic [31:0] r2, logic we,
                       logic [4:0] wa, logic [31:0] wd, logic v, logic er, logic fl);
    @(negedge clk);
    if_instr = ins; if_pc = pc; rf_data_rd1 = r1; rf_data_rd2 = r2; wb_wr_en = we; wb_addr = wa;
    wb_data = wd; if_valid = v; ex_ready = er; flush = fl;
    #1;
  endtask
  always begin
    @(negedge clk);
    #2;
    if (rst_n && ex_valid && ex_ready && !flush) begin
      m_a = '{ex_pc, ex_instr, ex_rs1, ex_rs2, ex_rd, ex_is_load, ex_rs1_data, ex_rs2_data};
      vecs++;
      if (q.size() == 0) begin
        errs++;
        $display("FAIL ex_entry: unexpected entry pc=%0h", ex_pc);
      end else begin
        m_e = q.pop_front();
        if (m_a !== m_e) begin
          errs++;
          $display("FAIL ex_entry: got pc=%0h ins=%0h rs=%0d/%0d rd=%0d ld=%0b op=%0h/%0h want pc=%0h ins=%0h rs=%0d/%0d rd=%0d ld=%0b op=%0h/%0h",
                   m_a.pc, m_a.instr, m_a.rs1, m_a.rs2, m_a.rd, m_a.ld, m_a.op1, m_a.op2,
                   m_e.pc, m_e.instr, m_e.rs1, m_e.rs2, m_e.rd, m_e.ld, m_e.op1, m_e.op2);
        end
      end
    end
  end
  initial begin
    tbl[0] = '{ADDI5, 32'h33, 32'h44, 1'b0, 5'd0, 32'h0,  32'h0,  32'h44};
    tbl[1] = '{ADDI8, 32'h11, 32'h22, 1'b1, 5'd3, 32'hAB, 32'hAB, 32'h22};
    tbl[2] = '{SW4,   32'h50, 32'h01, 1'b1, 5'd4, 32'h44, 32'h50, 32'h44};
    tbl[3] = '{ADD11, 32'h05, 32'h06, 1'b1, 5'd0, 32'hFF, 32'h0,  32'h0};
    tbl[4] = '{LUI9,  32'h0A, 32'h0B, 1'b1, 5'd9, 32'hCC, 32'h0A, 32'h0B};
    tbl[5] = '{ADD7,  32'h01, 32'h02, 1'b1, 5'd1, 32'h77, 32'h01, 32'h77};
    tbl[6] = '{LW6,   32'h03, 32'h09, 1'b0, 5'd0, 32'h0,  32'h03, 32'h0};
    if_valid = 0; if_instr = 0; if_pc = 0; flush = 0; rf_data_rd1 = 0; rf_data_rd2 = 0;
    wb_wr_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 0;
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_perf", perf_stall_cnt, 0);
    chk("rst_ex_pc", ex_pc, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].instr, 32'h100 + 32'(4 * i), tbl[i].rf1, tbl[i].rf2, tbl[i].we, tbl[i].wa, tbl[i].wd, 1, 1, 0);
      chk($sformatf("tbl%0d_if_ready", i), if_ready, 1);
      q.push_back(mk(32'h100 + 32'(4 * i), tbl[i].instr, tbl[i].op1, tbl[i].op2));
    end
    drive(LUI9, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("addr_rd1", rf_addr_rd1, 8);
    chk("addr_rd2", rf_addr_rd2, 3);
    for (int k = 0; k < 3; k++) begin
      drive(ADD7, 32'h200, 32'h11, 32'h7, 0, 0, 0, 1, 1, 0);
      chk($sformatf("stall%0d_if_ready", k), if_ready, 0);
      chk($sformatf("stall%0d_bubble", k), ex_valid, 0);
      chk($sformatf("stall%0d_perf", k), perf_stall_cnt, 32'(k));
    end
    drive(ADD7, 32'h200, 32'h11, 32'h7, 1, 6, 32'h55, 1, 1, 0);
    chk("wb_unstall_if_ready", if_ready, 1);
    chk("stall_perf_total", perf_stall_cnt, 3);
    q.push_back(mk(32'h200, ADD7, 32'h55, 32'h7));
    drive(ADD7, 32'h204, 32'h66, 32'h7, 0, 0, 0, 1, 1, 0);
    chk("busy6_cleared", if_ready, 1);
    chk("perf_no_inc", perf_stall_cnt, 3);
    q.push_back(mk(32'h204, ADD7, 32'h66, 32'h7));
    drive(ADD12, 32'h300, 32'h1, 32'h2, 0, 0, 0, 1, 1, 0);
    chk("hold_issue_if_ready", if_ready, 1);
    q.push_back(mk(32'h300, ADD12, 32'h1, 32'h99));
    drive(ADD7, 32'h304, 0, 0, 1, 4, 32'h99, 1, 0, 0);
    chk("hold_if_ready", if_ready, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("hold_ex_valid", ex_valid, 1);
    chk("snoop_rs2_data", ex_rs2_data, 32'h99);
    chk("hold_rs1_data", ex_rs1_data, 32'h1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("drained_ex_valid", ex_valid, 0);
    drive(LW6, 32'h400, 32'h3, 0, 0, 0, 0, 1, 1, 0);
    chk("flush_lw_if_ready", if_ready, 1);
    q.push_back(mk(32'h400, LW6, 32'h3, 32'h0));
    drive(ADDI5, 32'h404, 0, 32'h9, 0, 0, 0, 1, 1, 0);
    chk("flush_addi_if_ready", if_ready, 1);
    q.push_back(mk(32'h404, ADDI5, 32'h0, 32'h9));
    drive(ADDI5, 32'h408, 0, 0, 0, 0, 0, 1, 0, 1);
    chk("flush_if_ready", if_ready, 0);
    chk("preflush_ex_valid", ex_valid, 1);
    void'(q.pop_back());
    drive(ADD7, 32'h500, 32'h11, 32'h7, 0, 0, 0, 1, 1, 0);
    chk("postflush_ex_valid", ex_valid, 0);
    chk("flush_keeps_busy", if_ready, 0);
    drive(ADD7, 32'h500, 32'h11, 32'h7, 0, 0, 0, 1, 1, 0);
    chk("flush_stall_perf", perf_stall_cnt, 4);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_perf", perf_stall_cnt, 0);
    chk("arst_ex_pc", ex_pc, 0);
    chk("arst_rs2_data", ex_rs2_data, 0);
    drive(ADD7, 32'h508, 32'h77, 32'h7, 0, 0, 0, 1, 1, 0);
    rst_n = 1;
    #1;
    chk("post_rst_if_ready", if_ready, 1);
    q.push_back(mk(32'h508, ADD7, 32'h77, 32'h7));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("post_rst_ex_valid", ex_valid, 1);
    chk("post_rst_perf", perf_stall_cnt, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("queue_empty", 64'(q.size()), 0);
    chk("final_ex_valid", ex_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Decode/operand-fetch stage directly upstream of the register file's consumers.
- Accepts fetched instructions over a valid/ready handshake and drives the two register-file read addresses combinationally.
- Forwards same-cycle write-back data, which the register file does not forward internally.
- Tracks outstanding loads in a scoreboard to stall RAW hazards, and holds operands in an ID/EX pipeline register with a valid/ready handshake to EX.

Parameters:
DATA_WIDTH, 32, operand/register width (matches register file)
PC_WIDTH, 32, program counter width
CNT_WIDTH, 32, stall performance counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset
if_valid  input  1  fetch holds a valid instruction
if_ready  output  1  stage accepts instruction this cycle
if_instr  input  32  instruction word
if_pc  input  PC_WIDTH  instruction PC
flush  input  1  kill held ID/EX entry and block accept this cycle
rf_addr_rd1  output  5  register file read address 1 (= if_instr[19:15])
rf_addr_rd2  output  5  register file read address 2 (= if_instr[24:20])
rf_data_rd1  input  DATA_WIDTH  register file read data 1
rf_data_rd2  input  DATA_WIDTH  register file read data 2
wb_wr_en  input  1  write-back enable (same signal driving register file)
wb_addr  input  5  write-back address
wb_data  input  DATA_WIDTH  write-back data
ex_ready  input  1  EX accepts ID/EX entry
ex_valid  output  1  ID/EX entry valid
ex_pc  output  PC_WIDTH  captured PC
ex_instr  output  32  captured instruction
ex_rs1  output  5  captured rs1 address (for downstream forwarding)
ex_rs2  output  5  captured rs2 address
ex_rs1_data  output  DATA_WIDTH  operand 1
ex_rs2_data  output  DATA_WIDTH  operand 2
ex_rd  output  5  destination (instr[11:7])
ex_is_load  output  1  opcode == 7'b0000011
perf_stall_cnt  output  CNT_WIDTH  hazard stall cycles, saturating

Behaviour:
- Reset (async, active-low, clk/rst_n): ex_valid=0, all ex_* payload=0, scoreboard busy[31:0]=0, perf_stall_cnt=0.
- Read addresses:
  - rf_addr_rd1/rd2 are pure combinational slices of if_instr, independent of if_valid.
- Source use:
  - use_rs1=0 for LUI 0110111, AUIPC 0010111 and JAL 1101111; use_rs1=1 for all other opcodes.
  - use_rs2=1 only for R 0110011, S 0100011 and B 1100011.
- Bypass:
  - opX = (wb_wr_en && wb_addr!=0 && wb_addr==rsX) ? wb_data : rf_data_rdX.
  - rsX==0 always yields 0.
- Hazard:
  - hzd = (use_rs1 && busy[rs1] && !wb_hit1) || (use_rs2 && busy[rs2] && !wb_hit2).
  - wb_hitX = wb_wr_en && wb_addr==rsX.
  - A same-cycle write-back clears the stall.
- Handshake:
  - if_ready = !flush && !hzd && (!ex_valid || ex_ready), combinational.
  - accept = if_valid && if_ready.
- ID/EX register, at each posedge:
  - flush: ex_valid<=0.
  - else if (!ex_valid || ex_ready): ex_valid<=accept; on accept load pc, instr, rs1, rs2, rd, is_load, op1, op2. On a hazard a bubble is inserted (ex_valid=0).
  - else (holding): payload is stable, except snoop — if wb_wr_en && wb_addr!=0 && wb_addr==ex_rsX then ex_rsX_data<=wb_data.
- Scoreboard:
  - set busy[ex_rd] when ex_valid && ex_ready && ex_is_load && ex_rd!=0 && !flush.
  - clear busy[wb_addr] when wb_wr_en.
  - Same address set and clear in one cycle: set wins. busy[0] is never set.
  - flush does not clear the scoreboard: loads already past EX still write back.
- perf_stall_cnt:
  - +1 per cycle with if_valid && hzd && !flush; saturates at all-ones.
- Latency: one cycle from accept to ex_valid.
  - Back-to-back issue at full throughput when ex_ready=1 and there is no hazard.

Test Plan:
- ADDI x5,x0,7 with if_valid=1 and ex_ready=1 -> next cycle ex_valid=1, ex_rd=5, ex_rs1_data=0; if_ready=1 throughout.
- rf_data_rd1=0x11, same cycle wb_wr_en=1, wb_addr=rs1=3, wb_data=0xAB -> ex_rs1_data=0xAB.
- LW x6 handed to EX, then ADD x7,x6,x1 presented -> if_ready=0 and bubble each cycle, perf_stall_cnt increments; wb write x6=0x55 -> accepted that cycle, ex_rs1_data=0x55, busy[6]=0.
- ex_ready=0 holding ADD with rs2=4 while wb writes x4=0x99 -> ex_rs2_data becomes 0x99; when ex_ready=1 is raised the entry is consumed.
- flush=1 with ex_valid=1 -> next cycle ex_valid=0, if_ready=0 during flush, scoreboard unchanged.
- rst_n low mid-stall with busy[6]=1 -> all outputs 0 immediately, busy cleared; after release, ADD x7,x6,x1 accepted with no stall.
